// File: rtl/afc_vco_cntr.sv
// Frequency counter for the AFC loop: counts synchronized rising edges of the divided VCO
// while afc holds the count window open, and latches the result on a datasyn pulse.
module afc_vco_cntr #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 14
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             vco_div_in,
   input  logic             afc_cntr_rstn,
   input  logic             afc_cntr_en,
   input  logic             afc_cntr_datasyn,
   output logic [CNT_W-1:0] a2d_afc_ncntr,
   output logic             ncntr_valid,
   output logic             ncntr_ovf,
   output logic             cnt_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] vco_sync;
   logic                   vco_sync_d;
   logic                   edge_p;
   logic [CNT_W-1:0]       cnt;
   logic                   count_en;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Synchronizer and rising-edge detector; all-zero reset keeps the first edge honest
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vco_sync   <= '0;
         vco_sync_d <= 1'b0;
      end else begin
         vco_sync   <= {vco_sync[SYNC_STAGES-2:0], vco_div_in};
         vco_sync_d <= vco_sync[SYNC_STAGES-1];
      end
   end

   assign edge_p   = vco_sync[SYNC_STAGES-1] & ~vco_sync_d;
   assign count_en = (state == COUNT) & edge_p;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt_busy <= (state_nxt == COUNT);
      end
   end

   always_comb begin
      state_nxt = state;
      if (!afc_cntr_rstn) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (afc_cntr_en)  state_nxt = COUNT;
            COUNT:   if (!afc_cntr_en) state_nxt = HOLD;
            HOLD:    if (afc_cntr_en)  state_nxt = COUNT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Count engine: the local clear wins over counting; overflow is sticky per window
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt       <= '0;
         ncntr_ovf <= 1'b0;
      end else if (!afc_cntr_rstn) begin
         cnt       <= '0;
         ncntr_ovf <= 1'b0;
      end else if (count_en) begin
         cnt <= sat_inc(cnt);
         if (cnt == CNT_MAX) ncntr_ovf <= 1'b1;
      end
   end

   // Result latch takes the pre-increment count; a simultaneous clear suppresses it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a2d_afc_ncntr <= '0;
         ncntr_valid   <= 1'b0;
      end else begin
         ncntr_valid <= afc_cntr_datasyn & afc_cntr_rstn;
         if (afc_cntr_datasyn && afc_cntr_rstn) a2d_afc_ncntr <= cnt;
      end
   end

endmodule
